mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin memory arbiter: one init write after reset, then
// serialised ACCESS/RESP transactions with a registered completion pulse per requester.
module mem_arbiter #(
    parameter int unsigned           ADDR_WIDTH   = 16,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] CHIP_EN_ADDR = 'h20,
    parameter logic [ADDR_WIDTH-1:0] PARK_ADDR    = 'h18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  wr0,
    input  logic                  wr1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  ok0,
    output logic                  ok1,
    output logic                  busy,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_response
);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;

    logic                  r_cmd_wr,    w_cmd_wr;
    logic [ADDR_WIDTH-1:0] r_cmd_addr,  w_cmd_addr;
    logic [DATA_WIDTH-1:0] r_cmd_wdata, w_cmd_wdata;
    logic                  r_cmd_id,    w_cmd_id;
    logic                  r_last_grant, w_last_grant;

    logic                  r_done0, w_done0;
    logic                  r_done1, w_done1;
    logic [DATA_WIDTH-1:0] r_rdata0, w_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1, w_rdata1;
    logic                  r_ok0, w_ok0;
    logic                  r_ok1, w_ok1;
    logic                  r_busy, w_busy;
    logic                  r_mem_wr, w_mem_wr;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata;

    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_pick1;

    // A requester still showing its done pulse is not eligible; ties go to the one not granted last.
    assign w_elig0 = req0 & ~r_done0;
    assign w_elig1 = req1 & ~r_done1;
    assign w_pick1 = w_elig1 & (~w_elig0 | ~r_last_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_INIT;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cmd_wr     = r_cmd_wr;
        w_cmd_addr   = r_cmd_addr;
        w_cmd_wdata  = r_cmd_wdata;
        w_cmd_id     = r_cmd_id;
        w_last_grant = r_last_grant;
        w_done0      = 1'b0;
        w_done1      = 1'b0;
        w_rdata0     = r_rdata0;
        w_rdata1     = r_rdata1;
        w_ok0        = r_ok0;
        w_ok1        = r_ok1;
        w_mem_wr     = 1'b0;
        w_mem_addr   = PARK_ADDR;
        w_mem_wdata  = '0;

        case (r_state)
            S_INIT: w_state_nx = S_IDLE;
            S_IDLE: begin
                if (w_elig0 | w_elig1) begin
                    w_cmd_id     = w_pick1;
                    w_cmd_wr     = w_pick1 ? wr1    : wr0;
                    w_cmd_addr   = w_pick1 ? addr1  : addr0;
                    w_cmd_wdata  = w_pick1 ? wdata1 : wdata0;
                    w_last_grant = w_pick1;
                    w_state_nx   = S_ACCESS;
                end
            end
            S_ACCESS: w_state_nx = S_RESP;
            S_RESP: begin
                w_state_nx = S_IDLE;
                if (r_cmd_id) begin
                    w_done1 = 1'b1;
                    w_ok1   = r_cmd_wr ? mem_response : 1'b1;
                    if (!r_cmd_wr) w_rdata1 = mem_rdata;
                end else begin
                    w_done0 = 1'b1;
                    w_ok0   = r_cmd_wr ? mem_response : 1'b1;
                    if (!r_cmd_wr) w_rdata0 = mem_rdata;
                end
            end
            default: w_state_nx = S_INIT;
        endcase

        // Memory command is registered, so it is decoded from the state being entered.
        case (w_state_nx)
            S_INIT: begin
                w_mem_wr    = 1'b1;
                w_mem_addr  = CHIP_EN_ADDR;
                w_mem_wdata = DATA_WIDTH'(1);
            end
            S_ACCESS: begin
                w_mem_wr    = w_cmd_wr;
                w_mem_addr  = w_cmd_addr;
                w_mem_wdata = w_cmd_wdata;
            end
            default: ;
        endcase

        w_busy = (w_state_nx != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd_wr     <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
            r_cmd_id     <= 1'b0;
            r_last_grant <= 1'b1;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_ok0        <= 1'b0;
            r_ok1        <= 1'b0;
            r_busy       <= 1'b1;
            r_mem_wr     <= 1'b1;
            r_mem_addr   <= CHIP_EN_ADDR;
            r_mem_wdata  <= DATA_WIDTH'(1);
        end else begin
            r_cmd_wr     <= w_cmd_wr;
            r_cmd_addr   <= w_cmd_addr;
            r_cmd_wdata  <= w_cmd_wdata;
            r_cmd_id     <= w_cmd_id;
            r_last_grant <= w_last_grant;
            r_done0      <= w_done0;
            r_done1      <= w_done1;
            r_rdata0     <= w_rdata0;
            r_rdata1     <= w_rdata1;
            r_ok0        <= w_ok0;
            r_ok1        <= w_ok1;
            r_busy       <= w_busy;
            r_mem_wr     <= w_mem_wr;
            r_mem_addr   <= w_mem_addr;
            r_mem_wdata  <= w_mem_wdata;
        end
    end

    assign done0     = r_done0;
    assign done1     = r_done1;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign ok0       = r_ok0;
    assign ok1       = r_ok1;
    assign busy      = r_busy;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed bring-up/arbitration/reset cases, then two
// independent random requesters checked against a transaction-level memory model.
module tb_mem_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam logic [AW-1:0] CHIP_EN = 16'h20;
    localparam logic [AW-1:0] PARK    = 16'h18;
    localparam int unsigned N_RAND  = 25;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          done0, done1, ok0, ok1, busy, mem_wr;
    logic [DW-1:0] rdata0, rdata1, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_response = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [DW-1:0] env_mem   [64];
    logic [DW-1:0] model_mem [64];
    logic [DW-1:0] hold_rd   [2];
    logic          pending   [2];
    int            assert_cyc[2];
    int            last_done;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
        .ok0(ok0), .ok1(ok1), .busy(busy),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_response(mem_response)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory environment: one-cycle response latency, writes at 'h30 and above are dropped.
    logic [DW-1:0] pend_rdata = '0;
    logic          pend_resp  = 1'b0;
    always @(negedge clk) begin
        mem_rdata    = pend_rdata;
        mem_response = pend_resp;
        pend_rdata   = env_mem[mem_addr[5:0]];
        if (mem_wr) begin
            pend_resp = (mem_addr < 16'h30);
            if (pend_resp) env_mem[mem_addr[5:0]] = mem_wdata;
        end else begin
            pend_resp = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) if (done0 | done1) chk("done_exclusive", done0 & done1, 1'b0);

    function automatic void model_access(input logic wr, input logic [AW-1:0] a,
                                         input logic [DW-1:0] d,
                                         output logic [DW-1:0] rd, output logic ok);
        rd = '0;
        if (wr) begin
            ok = (a < 16'h30);
            if (ok) model_mem[a[5:0]] = d;
        end else begin
            ok = 1'b1;
            rd = model_mem[a[5:0]];
        end
    endfunction

    task automatic set_req(input int id, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id == 0) begin req0 = r; wr0 = w; addr0 = a; wdata0 = d; end
        else         begin req1 = r; wr1 = w; addr1 = a; wdata1 = d; end
        pending[id] = r;
        if (r) assert_cyc[id] = cyc;
    endtask

    task automatic check_release();
        reset = 1'b0;
        #1;
        chk("init_mem_wr", mem_wr, 1'b1);
        chk("init_mem_addr", mem_addr, CHIP_EN);
        chk("init_mem_wdata", mem_wdata, 1);
        chk("init_busy", busy, 1'b1);
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("idle_mem_wr", mem_wr, 1'b0);
        chk("idle_mem_addr", mem_addr, PARK);
        chk("idle_mem_wdata", mem_wdata, 0);
        last_done = 1;
    endtask

    // Single access with exact cycle-by-cycle expectations; caller ensures the arbiter is idle.
    task automatic single(input int id, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] erd;
        logic          eok;
        set_req(id, 1'b1, wr, a, d);
        @(negedge clk);
        chk("acc_busy", busy, 1'b1);
        chk("acc_mem_wr", mem_wr, wr);
        chk("acc_mem_addr", mem_addr, a);
        if (wr) chk("acc_mem_wdata", mem_wdata, d);
        @(negedge clk);
        chk("resp_no_done", done0 | done1, 1'b0);
        chk("resp_park", mem_addr, PARK);
        @(negedge clk);
        model_access(wr, a, d, erd, eok);
        if (!wr) hold_rd[id] = erd;
        chk("done_self", (id == 0) ? done0 : done1, 1'b1);
        chk("done_other", (id == 0) ? done1 : done0, 1'b0);
        chk("ok", (id == 0) ? ok0 : ok1, eok);
        chk("rdata", (id == 0) ? rdata0 : rdata1, hold_rd[id]);
        set_req(id, 1'b0, 1'b0, '0, '0);
        last_done = id;
        @(negedge clk);
        chk("done_one_cycle", (id == 0) ? done0 : done1, 1'b0);
        chk("ok_hold", (id == 0) ? ok0 : ok1, eok);
        chk("idle_again", busy, 1'b0);
    endtask

    task automatic drive(input int id);
        logic          w, got, eok, rr_ok;
        logic [AW-1:0] a;
        logic [DW-1:0] d, erd;
        int            other, grant_c;
        other = 1 - id;
        for (int n = 0; n < N_RAND; n++) begin
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 4) == 0) ? 16'h30 + 16'($urandom_range(0, 3))
                                             : 16'($urandom_range(0, 15));
            d = $urandom;
            set_req(id, 1'b1, w, a, d);
            got = 1'b0;
            for (int t = 0; t < 30 && !got; t++) begin
                @(negedge clk);
                got = (id == 0) ? done0 : done1;
            end
            chk("done_seen", got, 1'b1);
            grant_c = cyc - 2;
            rr_ok = !(last_done == id && pending[other] && (assert_cyc[other] + 1 <= grant_c));
            chk("rr_order", rr_ok, 1'b1);
            model_access(w, a, d, erd, eok);
            if (!w) hold_rd[id] = erd;
            chk("rnd_ok", (id == 0) ? ok0 : ok1, eok);
            chk("rnd_rdata", (id == 0) ? rdata0 : rdata1, hold_rd[id]);
            last_done = id;
            set_req(id, 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            chk("rnd_pulse", (id == 0) ? done0 : done1, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, k, id_i;
        logic [DW-1:0] erd;
        logic eok;
        for (int i = 0; i < 64; i++) begin env_mem[i] = '0; model_mem[i] = '0; end
        hold_rd[0] = '0; hold_rd[1] = '0;
        pending[0] = 1'b0; pending[1] = 1'b0;
        assert_cyc[0] = 0; assert_cyc[1] = 0;
        last_done = 1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b1);
        chk("rst_done0", done0, 1'b0);
        chk("rst_done1", done1, 1'b0);
        chk("rst_ok0", ok0, 1'b0);
        chk("rst_rdata1", rdata1, 0);
        check_release();

        single(0, 1'b1, 16'h3, 32'hA5);
        single(1, 1'b0, 16'h3, '0);
        single(0, 1'b1, 16'h30, 32'h1234);

        // Both held: completions alternate every 3 cycles starting with the one not served last.
        first = 1 - last_done;
        set_req(0, 1'b1, 1'b0, 16'h3, '0);
        set_req(1, 1'b1, 1'b0, 16'h4, '0);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            k    = i / 3 - 1;
            id_i = first ^ (k & 1);
            chk("rr_done0", done0, (i % 3 == 0) && (id_i == 0));
            chk("rr_done1", done1, (i % 3 == 0) && (id_i == 1));
            if (i % 3 == 0) begin
                model_access(1'b0, (id_i == 0) ? 16'h3 : 16'h4, '0, erd, eok);
                chk("rr_rdata", (id_i == 0) ? rdata0 : rdata1, erd);
                hold_rd[id_i] = erd;
                last_done = id_i;
            end
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        chk("rr_quiet", busy, 1'b0);

        // Reset in the middle of an access discards it.
        set_req(0, 1'b1, 1'b0, 16'h5, '0);
        @(negedge clk);
        chk("pre_rst_access", mem_addr, 16'h5);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b1);
        chk("mid_rst_mem_wr", mem_wr, 1'b1);
        chk("mid_rst_mem_addr", mem_addr, CHIP_EN);
        chk("mid_rst_ok0", ok0, 1'b0);
        chk("mid_rst_rdata0", rdata0, 0);
        chk("mid_rst_ok1", ok1, 1'b0);
        set_req(0, 1'b0, 1'b0, '0, '0);
        hold_rd[0] = '0; hold_rd[1] = '0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_done", done0 | done1, 1'b0);
        end
        check_release();
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_done", done0 | done1, 1'b0);
        end

        fork
            drive(0);
            drive(1);
        join
        repeat (3) @(negedge clk);
        chk("final_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
